// File: rtl/rvfi_retire_buffer_if.sv
// Retire-buffer handshake bundle: multi-lane retire input and a single
// valid/ready drain output.
interface rvfi_retire_buffer_if #(
  parameter int NRET  = 2,
  parameter int PKT_W = 233
);
  logic [NRET-1:0]       in_valid_i;
  logic [NRET*PKT_W-1:0] in_pkt_i;
  logic                  in_ready_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [PKT_W-1:0]      out_pkt_o;
  logic [63:0]           out_order_o;

  modport master (
    output in_valid_i, in_pkt_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pkt_o, out_order_o
  );

  modport slave (
    input  in_valid_i, in_pkt_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pkt_o, out_order_o
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// Compacting, order-tagging RVFI retire trace buffer.
// Accepts up to NRET packets per cycle, drains one per cycle.
module rvfi_retire_buffer #(
  parameter int NRET          = 2,
  parameter int DEPTH         = 16,
  parameter int PKT_W         = 233,
  parameter bit STALL_ON_FULL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  rvfi_retire_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            drop_cnt_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [PKT_W-1:0] mem_pkt [DEPTH];
  logic [63:0]      mem_ord [DEPTH];

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  logic [63:0] order_q;

  cnt_t        n;
  cnt_t        free;
  ptr_t        off  [NRET];
  ptr_t        widx [NRET];
  logic        space_ok;
  logic        push;
  logic        drop;
  logic        pop;
  logic [32:0] drop_sum;

  // Lane k lands at wr_ptr + (number of valid lanes below k).
  always_comb begin
    n = '0;
    for (int k = 0; k < NRET; k++) begin
      off[k]  = n[AW-1:0];
      widx[k] = wr_ptr + n[AW-1:0];
      n       = n + cnt_t'(bus.in_valid_i[k]);
    end
  end

  // No pop credit in the space check: keeps in_ready off the out_ready path.
  assign free     = cnt_t'(DEPTH) - count_o;
  assign space_ok = free >= cnt_t'(NRET);
  assign push     = space_ok && (n != '0);
  assign drop     = !STALL_ON_FULL && !space_ok && (n != '0);
  assign pop      = bus.out_valid_o && bus.out_ready_i;
  assign drop_sum = {1'b0, drop_cnt_o} + 33'(n);

  assign bus.in_ready_o  = STALL_ON_FULL ? space_ok : 1'b1;
  assign bus.out_valid_o = (count_o != '0);
  assign bus.out_pkt_o   = mem_pkt[rd_ptr];
  assign bus.out_order_o = mem_ord[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      order_q    <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + n[AW-1:0];
      if (pop)
        rd_ptr <= rd_ptr + ptr_t'(1);
      count_o <= count_o + (push ? n : '0) - cnt_t'(pop);
      // Dropped packets still burn order numbers so loss shows as a gap.
      if (push || drop)
        order_q <= order_q + 64'(n);
      if (drop) begin
        drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
        overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (push && bus.in_valid_i[k]) begin
        mem_pkt[widx[k]] <= bus.in_pkt_i[k*PKT_W +: PKT_W];
        mem_ord[widx[k]] <= order_q + 64'(off[k]);
      end
    end
  end
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Bench for rvfi_retire_buffer: stall and drop variants side by side,
// table vectors, directed corners and a queue-based reference model.
module tb_rvfi_retire_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   vi  = '0;
  logic [232:0] p0  = '0;
  logic [232:0] p1  = '0;
  logic         ordy = 1'b0;
  bit           sel  = 1'b0;

  always #5 clk = ~clk;

  rvfi_retire_buffer_if #(.NRET(2), .PKT_W(233)) b0 ();
  rvfi_retire_buffer_if #(.NRET(2), .PKT_W(233)) b1 ();

  assign b0.in_valid_i  = vi;
  assign b0.in_pkt_i    = {p1, p0};
  assign b0.out_ready_i = ordy;
  assign b1.in_valid_i  = vi;
  assign b1.in_pkt_i    = {p1, p0};
  assign b1.out_ready_i = ordy;

  logic [4:0]  c0, c1;
  logic [31:0] d0, d1;
  logic        o0, o1;

  rvfi_retire_buffer #(
    .NRET(2), .DEPTH(16), .PKT_W(233), .STALL_ON_FULL(1'b1)
  ) u_s (
    .clk(clk), .rst(rst), .bus(b0),
    .count_o(c0), .drop_cnt_o(d0), .overflow_o(o0)
  );

  rvfi_retire_buffer #(
    .NRET(2), .DEPTH(16), .PKT_W(233), .STALL_ON_FULL(1'b0)
  ) u_d (
    .clk(clk), .rst(rst), .bus(b1),
    .count_o(c1), .drop_cnt_o(d1), .overflow_o(o1)
  );

  logic         a_rdy, a_val, a_ovf;
  logic [232:0] a_pkt;
  logic [63:0]  a_ord;
  logic [4:0]   a_cnt;
  logic [31:0]  a_drop;

  always_comb begin
    if (sel) begin
      a_rdy = b1.in_ready_o; a_val = b1.out_valid_o;
      a_pkt = b1.out_pkt_o;  a_ord = b1.out_order_o;
      a_cnt = c1; a_drop = d1; a_ovf = o1;
    end else begin
      a_rdy = b0.in_ready_o; a_val = b0.out_valid_o;
      a_pkt = b0.out_pkt_o;  a_ord = b0.out_order_o;
      a_cnt = c0; a_drop = d0; a_ovf = o0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [232:0] mk(int unsigned id);
    logic [232:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      r[b*29 +: 29] = 29'(id * 32'h9E3779B1 + 32'(b));
    r[232] = id[0];
    return r;
  endfunction

  // Reference model: a queue of {packet, order} plus counters.
  typedef struct {
    logic [232:0]    pkt;
    longint unsigned ord;
  } ent_t;

  ent_t            mq[$];
  longint unsigned m_ord  = 0;
  longint unsigned m_drop = 0;
  bit              m_ovf  = 1'b0;
  bit              last_acc = 1'b0;
  int              n_pop = 0;
  int unsigned     pid = 1000;

  task automatic do_reset();
    rst  = 1'b1;
    vi   = '0;
    ordy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ord  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic beat(logic [1:0] v);
    vi = v;
    p0 = mk(pid);
    p1 = mk(pid + 1);
    pid += 2;
  endtask

  task automatic mstep(string tag);
    int   n;
    bit   sok, acc, drp, pp;
    ent_t e;
    #1;
    sok = (16 - mq.size()) >= 2;
    chk({tag, "_valid"}, 256'(a_val), 256'(mq.size() != 0));
    chk({tag, "_count"}, 256'(a_cnt), 256'(mq.size()));
    chk({tag, "_ready"}, 256'(a_rdy), 256'(sel ? 1'b1 : sok));
    chk({tag, "_drop"}, 256'(a_drop), 256'(m_drop));
    chk({tag, "_ovf"}, 256'(a_ovf), 256'(m_ovf));
    if (mq.size() != 0) begin
      chk({tag, "_order"}, 256'(a_ord), 256'(mq[0].ord));
      chk({tag, "_pkt"}, 256'(a_pkt), 256'(mq[0].pkt));
    end
    n   = int'(vi[0]) + int'(vi[1]);
    pp  = (mq.size() != 0) && ordy;
    acc = (n > 0) && sok;
    drp = sel && (n > 0) && !sok;
    last_acc = acc;
    @(posedge clk);
    if (pp) begin
      e = mq.pop_front();
      n_pop++;
    end
    if (acc) begin
      if (vi[0]) begin e.pkt = p0; e.ord = m_ord; mq.push_back(e); m_ord++; end
      if (vi[1]) begin e.pkt = p1; e.ord = m_ord; mq.push_back(e); m_ord++; end
    end
    if (drp) begin
      m_ord += longint'(n);
      m_drop = (m_drop + longint'(n) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
                                                      : m_drop + longint'(n);
      m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit              rb;
    logic [1:0]      vi;
    bit              ordy;
    bit              ev;
    longint unsigned eo;
    int              ecnt;
    bit              erdy;
    int unsigned     eid;
  } row_t;

  row_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 2'b11, 1'b1, 1'b0, 0, 0, 1'b1, 0};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 1'b1, 0, 2, 1'b1, 100};
    tbl[2] = '{1'b0, 2'b00, 1'b1, 1'b1, 1, 1, 1'b1, 101};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1, 0};
    tbl[4] = '{1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b1, 0};
    tbl[5] = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1, 1'b1, 109};
    tbl[6] = '{1'b0, 2'b00, 1'b1, 1'b1, 1, 1, 1'b1, 110};
    tbl[7] = '{1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1'b1, 0};

    @(negedge clk);
    sel = 1'b0;

    // Table vectors on the stall variant.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rb) do_reset();
      vi   = tbl[i].vi;
      ordy = tbl[i].ordy;
      p0   = mk(100 + 2 * i);
      p1   = mk(101 + 2 * i);
      #1;
      chk($sformatf("tbl%0d_valid", i), 256'(a_val), 256'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i), 256'(a_cnt), 256'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ready", i), 256'(a_rdy), 256'(tbl[i].erdy));
      chk($sformatf("tbl%0d_ovf", i), 256'(a_ovf), 256'(0));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_order", i), 256'(a_ord), 256'(tbl[i].eo));
        chk($sformatf("tbl%0d_pkt", i), 256'(a_pkt), 256'(mk(tbl[i].eid)));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Stall fill: reach 15, stall, single pop, held beat lands after.
    do_reset();
    ordy = 1'b0;
    beat(2'b01);
    mstep("fill");
    for (int i = 0; i < 7; i++) begin
      beat(2'b11);
      mstep("fill");
    end
    beat(2'b11);
    #1;
    chk("fill_ready_low", 256'(a_rdy), 256'(0));
    chk("fill_count15", 256'(a_cnt), 256'(15));
    mstep("fill_hold");
    ordy = 1'b1;
    mstep("fill_pop");
    ordy = 1'b0;
    #1;
    chk("fill_ready_back", 256'(a_rdy), 256'(1));
    mstep("fill_acc");
    vi   = '0;
    ordy = 1'b1;
    for (int i = 0; i < 16; i++) mstep("fill_drain");
    beat(2'b01);
    mstep("fill_next");
    vi = '0;
    #1;
    chk("fill_contig_order", 256'(a_ord), 256'(17));
    mstep("fill_last");

    // Drop mode: overflow a full buffer, then see the order gap.
    sel = 1'b1;
    do_reset();
    ordy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(2'b11);
      mstep("drop_fill");
    end
    beat(2'b11);
    mstep("drop_ovf");
    vi = '0;
    #1;
    chk("drop_cnt2", 256'(a_drop), 256'(2));
    chk("drop_sticky", 256'(a_ovf), 256'(1));
    chk("drop_count16", 256'(a_cnt), 256'(16));
    ordy = 1'b1;
    mstep("drop_pop");
    mstep("drop_pop");
    ordy = 1'b0;
    beat(2'b01);
    mstep("drop_gap");
    vi   = '0;
    ordy = 1'b1;
    for (int i = 0; i < 14; i++) mstep("drop_drain");
    #1;
    chk("drop_gap_order", 256'(a_ord), 256'(18));
    chk("drop_gap_count", 256'(a_cnt), 256'(1));
    mstep("drop_tail");

    // Reset mid-operation with 9 entries and sticky overflow set.
    ordy = 1'b0;
    beat(2'b01);
    mstep("mid_fill");
    for (int i = 0; i < 4; i++) begin
      beat(2'b11);
      mstep("mid_fill");
    end
    vi = '0;
    #1;
    chk("mid_count9", 256'(a_cnt), 256'(9));
    do_reset();
    #1;
    chk("rst_count", 256'(a_cnt), 256'(0));
    chk("rst_valid", 256'(a_val), 256'(0));
    chk("rst_drop", 256'(a_drop), 256'(0));
    chk("rst_ovf", 256'(a_ovf), 256'(0));
    chk("rst_ready", 256'(a_rdy), 256'(1));
    ordy = 1'b1;
    beat(2'b11);
    mstep("rst_push");
    vi = '0;
    #1;
    chk("rst_order0", 256'(a_ord), 256'(0));
    mstep("rst_pop");
    mstep("rst_pop");

    // Wrap: 40 packets, odd start so a beat straddles slot 15 -> 0.
    sel = 1'b0;
    do_reset();
    n_pop = 0;
    begin
      int sent = 0;
      vi = '0;
      for (int c = 0; c < 300 && (sent < 40 || mq.size() != 0); c++) begin
        ordy = (c % 2 == 0);
        if (vi == '0 && sent < 40)
          beat((sent == 0 || sent == 39) ? 2'b01 : 2'b11);
        mstep("wrap");
        if (last_acc) begin
          sent += int'(vi[0]) + int'(vi[1]);
          vi = '0;
        end
      end
      #1;
      chk("wrap_sent", 256'(sent), 256'(40));
      chk("wrap_pops", 256'(n_pop), 256'(40));
      chk("wrap_empty", 256'(a_cnt), 256'(0));
    end

    // Randomized traffic in both modes against the queue model.
    for (int m = 0; m < 2; m++) begin
      bit hold = 1'b0;
      sel = (m == 1);
      do_reset();
      for (int i = 0; i < 500; i++) begin
        ordy = ($urandom_range(0, 9) < 4);
        if (!hold) begin
          vi = 2'($urandom_range(0, 3));
          p0 = mk(pid);
          p1 = mk(pid + 1);
          pid += 2;
        end
        mstep(m == 1 ? "rnd_drop" : "rnd_stall");
        hold = !sel && (vi != '0) && !last_acc;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
